// File: rtl/alu_seq.sv
// alu_seq: sequences one wide operation over an external 8-bit ALU, one word per cycle
module alu_seq #(
  parameter int ALU_rozm_data = 8,
  parameter int LICZBA_SLOW   = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [3:0]                             op,
  input  logic                                   c_in,
  input  logic [LICZBA_SLOW*ALU_rozm_data-1:0]   opa,
  input  logic [LICZBA_SLOW*ALU_rozm_data-1:0]   opb,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err,
  output logic [LICZBA_SLOW*ALU_rozm_data-1:0]   wynik,
  output logic                                   C,
  output logic                                   Z,
  output logic                                   S,
  output logic                                   P,
  output logic                                   OV,
  output logic [ALU_rozm_data-1:0]               alu_a,
  output logic [ALU_rozm_data-1:0]               alu_b,
  output logic [3:0]                             alu_op,
  output logic                                   alu_c_in,
  input  logic [ALU_rozm_data-1:0]               alu_out,
  input  logic                                   alu_C
);
  localparam int W  = ALU_rozm_data;
  localparam int N  = LICZBA_SLOW;
  localparam int WW = N * W;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_INK  = 4'b0110;
  localparam logic [3:0] OP_ADDC = 4'b1000;
  localparam logic [3:0] OP_SUBC = 4'b1001;
  localparam logic [3:0] OP_MAX  = 4'b1001;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic            cr;
  logic [WW-1:0]   opa_r, opb_r;
  logic [3:0]      op_r;
  logic            c_r;
  logic [WW-1:0]   w_nxt;
  logic            first, add_c, sub_c, arith, chain_in, ov_nxt;

  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign first    = k == '0;
  assign add_c    = op_r == OP_ADD || op_r == OP_INK || op_r == OP_ADDC;
  assign sub_c    = op_r == OP_SUB || op_r == OP_SUBC;
  assign arith    = add_c || sub_c;
  assign chain_in = op_r == OP_ADDC || op_r == OP_SUBC;

  // ALU drive for the current word; INK becomes a +1 ripple through the add chain
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = '0;
    alu_c_in = 1'b0;
    if (state == RUN) begin
      alu_a    = opa_r[k*W +: W];
      alu_b    = op_r == OP_INK ? (first ? W'(1) : '0) : opb_r[k*W +: W];
      alu_op   = add_c ? (chain_in || !first ? OP_ADDC : OP_ADD) :
                 sub_c ? (chain_in || !first ? OP_SUBC : OP_SUB) : op_r;
      alu_c_in = arith && (first ? chain_in && c_r : cr);
    end
  end

  // result as it will be after this edge, so flags see the top word too
  always_comb begin
    w_nxt = wynik;
    w_nxt[k*W +: W] = alu_out;
    ov_nxt = add_c ? (alu_a[W-1] & alu_b[W-1] & ~alu_out[W-1]) | (~alu_a[W-1] & ~alu_b[W-1] & alu_out[W-1]) :
             sub_c ? (alu_a[W-1] & ~alu_b[W-1] & ~alu_out[W-1]) | (~alu_a[W-1] & alu_b[W-1] & alu_out[W-1]) :
             1'b0;
  end

  // control FSM with word index, carry chain, result and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      cr    <= 1'b0;
      opa_r <= '0;
      opb_r <= '0;
      op_r  <= '0;
      c_r   <= 1'b0;
      err   <= 1'b0;
      wynik <= '0;
      C     <= 1'b0;
      Z     <= 1'b0;
      S     <= 1'b0;
      P     <= 1'b0;
      OV    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          err <= op > OP_MAX;
          if (op > OP_MAX) state <= DONE;
          else begin
            state <= RUN;
            k     <= '0;
            opa_r <= opa;
            opb_r <= opb;
            op_r  <= op;
            c_r   <= c_in;
          end
        end
        RUN: begin
          wynik <= w_nxt;
          cr    <= alu_C;
          if (k == KW'(N - 1)) begin
            state <= DONE;
            C     <= arith & alu_C;
            Z     <= w_nxt == '0;
            S     <= w_nxt[WW-1];
            P     <= ~^w_nxt;
            OV    <= ov_nxt;
          end else k <= k + KW'(1);
        end
        DONE: begin
          state <= IDLE;
          k     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq against a behavioural 8-bit ALU
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n, start, c_in;
  logic [3:0]  op;
  logic [31:0] opa, opb, wynik;
  logic        busy, done, err, C, Z, S, P, OV;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  logic        alu_c_in, alu_C;
  logic [8:0]  t;
  logic [3:0]  ops [8];
  int          total = 0, passes = 0, fails = 0, cyc, dn;

  alu_seq #(.ALU_rozm_data(8), .LICZBA_SLOW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .c_in(c_in),
    .opa(opa), .opb(opb), .busy(busy), .done(done), .err(err), .wynik(wynik),
    .C(C), .Z(Z), .S(S), .P(P), .OV(OV),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c_in(alu_c_in),
    .alu_out(alu_out), .alu_C(alu_C)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      4'h0: t = {1'b0, alu_b};
      4'h1: t = {1'b0, alu_a & alu_b};
      4'h2: t = {1'b0, alu_a | alu_b};
      4'h3: t = {1'b0, alu_a ^ alu_b};
      4'h4: t = {1'b0, alu_a} + {1'b0, alu_b};
      4'h5: t = {1'b0, alu_a} - {1'b0, alu_b};
      4'h6: t = {1'b0, alu_a} + 9'd1;
      4'h7: t = {1'b0, ~alu_a};
      4'h8: t = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_c_in};
      4'h9: t = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, alu_c_in};
      default: t = '0;
    endcase
    alu_out = t[7:0];
    alu_C   = t[8];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic ci, output int n);
    if (done) begin
      @(posedge clk);
      #1;
    end
    op = o; opa = a; opb = b; c_in = ci; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    for (int i = 0; i < 8; i++) ops[i] = 4'hF;
    while (!done && n < 20) begin
      if (n < 9) ops[n-1] = alu_op;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; c_in = 1'b0; opa = '0; opb = '0;
    #3;
    chk("rst_wynik", wynik, 0);
    chk("rst_flags", {C, Z, S, P, OV}, 0);
    chk("rst_ctl", {busy, done, err}, 0);
    chk("rst_alu", {alu_a, alu_b, alu_op, alu_c_in}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    go(4'h4, 32'h000000FF, 32'h00000001, 1'b0, cyc);
    chk("add1_lat", cyc, 5);
    chk("add1_w", wynik, 32'h00000100);
    chk("add1_flags", {C, Z, S, P, OV}, 5'b00000);
    chk("add1_busy_err", {busy, err}, 2'b10);
    go(4'h4, 32'hFFFFFFFF, 32'h00000001, 1'b0, cyc);
    chk("add2_w", wynik, 32'h0);
    chk("add2_flags", {C, Z, S, P, OV}, 5'b11010);
    chk("add2_ops", {ops[0], ops[1], ops[2], ops[3]}, 16'h4888);
    go(4'h5, 32'h00000000, 32'h00000001, 1'b0, cyc);
    chk("sub1_w", wynik, 32'hFFFFFFFF);
    chk("sub1_flags", {C, Z, S, P, OV}, 5'b10110);
    go(4'h5, 32'h80000000, 32'h00000001, 1'b0, cyc);
    chk("sub2_w", wynik, 32'h7FFFFFFF);
    chk("sub2_flags", {C, Z, S, P, OV}, 5'b00001);
    chk("sub2_ops", {ops[0], ops[1], ops[2], ops[3]}, 16'h5999);
    go(4'h8, 32'h7FFFFFFF, 32'h00000000, 1'b1, cyc);
    chk("addc_w", wynik, 32'h80000000);
    chk("addc_flags", {C, Z, S, P, OV}, 5'b00101);
    chk("addc_ops", {ops[0], ops[1], ops[2], ops[3]}, 16'h8888);
    go(4'h6, 32'h0000FFFF, 32'h00000000, 1'b0, cyc);
    chk("ink_w", wynik, 32'h00010000);
    chk("ink_flags", {C, Z, S, P, OV}, 5'b00000);
    go(4'h3, 32'hA5A5A5A5, 32'hFFFF0000, 1'b0, cyc);
    chk("xor_lat", cyc, 5);
    chk("xor_w", wynik, 32'h5A5AA5A5);
    chk("xor_flags", {C, Z, S, P, OV}, 5'b00010);
    chk("xor_ops", {ops[0], ops[1], ops[2], ops[3]}, 16'h3333);
    go(4'hC, 32'h12345678, 32'h11111111, 1'b0, cyc);
    chk("ill_lat", cyc, 1);
    chk("ill_ctl", {busy, done, err}, 3'b111);
    chk("ill_w", wynik, 32'h5A5AA5A5);
    chk("ill_flags", {C, Z, S, P, OV}, 5'b00010);
    chk("ill_alu", {alu_a, alu_b, alu_op, alu_c_in}, 0);
    @(posedge clk);
    #1;
    op = 4'h4; opa = 32'h000000FF; opb = 32'h00000001; start = 1'b1;
    @(posedge clk);
    #1;
    chk("acc_err_clr", {busy, err}, 2'b10);
    op = 4'h3;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ign_k1_op", alu_op, 4'h8);
    @(posedge clk);
    #1;
    chk("ign_k2_op", {busy, alu_op, alu_c_in}, {1'b1, 4'h8, 1'b0});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wynik", wynik, 0);
    chk("mid_rst_flags", {C, Z, S, P, OV}, 0);
    chk("mid_rst_ctl", {busy, done, err}, 0);
    chk("mid_rst_alu", {alu_a, alu_b, alu_op, alu_c_in}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    dn = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      dn += int'(done);
    end
    chk("no_done_after_rst", dn, 0);
    go(4'h4, 32'h000000FF, 32'h00000001, 1'b0, cyc);
    chk("post_rst_lat", cyc, 5);
    chk("post_rst_w", wynik, 32'h00000100);
    chk("post_rst_flags", {C, Z, S, P, OV}, 5'b00000);
    @(posedge clk);
    #1;
    chk("post_done_idle", {busy, done}, 2'b00);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
